// File: rtl/branch_redirect_unit.sv
// MEM-stage branch/jump resolver: decodes EX/MEM branch fields, registers the
// redirect PC and holds the segment-register flush strobes for FLUSH_CYCLES.

module bru_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)                             r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}})) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module branch_redirect_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_in,
  input  logic [25:0]      target_in,
  input  logic [31:0]      imm32_in,
  input  logic [31:0]      RegtoJump_in,
  input  logic             Zero_in,
  input  logic             Sign_in,
  input  logic [2:0]       Branchctr_in,
  input  logic [1:0]       Jumpctr_in,
  input  logic             stall_in,
  output logic             Branch_fc,
  output logic             Jump_fc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] jump_cnt
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] LP_CNT_LD = 4'(FLUSH_CYCLES - 1);
  localparam bit         LP_MULTI  = (FLUSH_CYCLES > 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_bfc, w_bfc_nxt;
  logic        r_jfc, w_jfc_nxt;
  logic        r_rv, w_rv_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        w_inc_taken, w_inc_jump;

  logic        w_br_taken, w_jump, w_event;
  logic [31:0] w_imm_sh, w_br_target, w_j_target, w_target;

  always_comb begin
    case (Branchctr_in)
      3'b001:  w_br_taken = Zero_in;
      3'b010:  w_br_taken = !Zero_in;
      3'b011:  w_br_taken = !Sign_in;
      3'b100:  w_br_taken = !Sign_in && !Zero_in;
      3'b101:  w_br_taken = Sign_in || Zero_in;
      3'b110:  w_br_taken = Sign_in;
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_jump      = (Jumpctr_in != 2'b00);
  assign w_event     = w_jump || w_br_taken;
  assign w_imm_sh    = imm32_in << 2;
  assign w_br_target = pc_in + w_imm_sh;
  assign w_j_target  = {pc_in[31:28], target_in, 2'b00};
  // A jump outranks a taken branch, so the branch target only matters when Jumpctr is zero.
  assign w_target    = (Jumpctr_in == 2'b11) ? RegtoJump_in :
                       w_jump                ? w_j_target   : w_br_target;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bfc_nxt   = r_bfc;
    w_jfc_nxt   = r_jfc;
    w_rv_nxt    = r_rv;
    w_pc_nxt    = r_pc;
    w_inc_taken = 1'b0;
    w_inc_jump  = 1'b0;
    if (!stall_in) begin
      w_rv_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          // With a one-cycle flush the strobe is cleared here on the following edge.
          w_bfc_nxt = 1'b0;
          w_jfc_nxt = 1'b0;
          if (w_event) begin
            w_rv_nxt    = 1'b1;
            w_pc_nxt    = w_target;
            w_jfc_nxt   = w_jump;
            w_bfc_nxt   = !w_jump;
            w_cnt_nxt   = LP_CNT_LD;
            w_inc_jump  = w_jump;
            w_inc_taken = !w_jump;
            w_state_nxt = LP_MULTI ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          if (r_cnt == 4'd0) begin
            w_bfc_nxt   = 1'b0;
            w_jfc_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_bfc   <= 1'b0;
      r_jfc   <= 1'b0;
      r_rv    <= 1'b0;
      r_pc    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bfc   <= w_bfc_nxt;
      r_jfc   <= w_jfc_nxt;
      r_rv    <= w_rv_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  bru_sat_cnt #(.W(CNT_W)) u_taken_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_inc_taken), .o_cnt(taken_cnt)
  );

  bru_sat_cnt #(.W(CNT_W)) u_jump_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_inc_jump), .o_cnt(jump_cnt)
  );

  assign Branch_fc      = r_bfc;
  assign Jump_fc        = r_jfc;
  assign redirect_valid = r_rv;
  assign redirect_pc    = r_pc;
  assign busy           = (r_state == FLUSH);
endmodule
